// File: rtl/comparador_serie_d_i_if.sv
// Request/result bus of the bit-serial comparator.
//   start, modo, a_in, b_in : request issued by the master (word pair + mode)
//   ocupado, listo, resultado : status and result returned by the slave
interface comparador_serie_d_i_if #(
   parameter int unsigned N = 8
);
   logic         start;
   logic         modo;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         ocupado;
   logic         listo;
   logic         resultado;

   modport master (
      output start, modo, a_in, b_in,
      input  ocupado, listo, resultado
   );

   modport slave (
      input  start, modo, a_in, b_in,
      output ocupado, listo, resultado
   );
endinterface

// File: rtl/comparador_serie_d_i.sv
// Bit-serial unsigned magnitude comparator, LSB first.
// Loads A/B on start, shifts one bit per clock while tracking the borrow of
// A - B - modo, then presents the MSB and running borrow to an external final
// cell and captures its p_x answer as the result (1 iff A >= B + modo).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result bus (slave side)
//   p_x        : final cell output (combinational from a_p/b_p/x_p)
//   a_p, b_p   : current A/B bit (LSB of the shift registers)
//   x_p        : current borrow state
//   ultimo     : MSB is being presented to the final cell
module comparador_serie_d_i #(
   parameter int unsigned N = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   comparador_serie_d_i_if.slave  bus,
   input  logic                   p_x,
   output logic                   a_p,
   output logic                   b_p,
   output logic                   x_p,
   output logic                   ultimo
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      DESPLAZA = 2'd1,
      FINAL    = 2'd2
   } estado_t;

   estado_t       r_estado;
   logic [N-1:0]  r_sa;
   logic [N-1:0]  r_sb;
   logic          r_x;
   logic [CW-1:0] r_cnt;
   logic          r_resultado;
   logic          r_listo;
   logic          w_borrow;

   // Borrow-out of a - b - x for the bit currently at the LSB.
   assign w_borrow = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_x) | (r_sb[0] & r_x);

   // Main sequencer: load, shift N-1 intermediate bits, hand MSB to final cell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado    <= REPOSO;
         r_sa        <= '0;
         r_sb        <= '0;
         r_x         <= 1'b0;
         r_cnt       <= '0;
         r_resultado <= 1'b0;
         r_listo     <= 1'b0;
      end else begin
         r_listo <= 1'b0;
         case (r_estado)
            REPOSO: begin
               if (bus.start) begin
                  r_sa     <= bus.a_in;
                  r_sb     <= bus.b_in;
                  r_x      <= bus.modo;
                  r_cnt    <= '0;
                  r_estado <= DESPLAZA;
               end
            end
            DESPLAZA: begin
               r_x   <= w_borrow;
               r_sa  <= {1'b0, r_sa[N-1:1]};
               r_sb  <= {1'b0, r_sb[N-1:1]};
               r_cnt <= r_cnt + CW'(1);
               // After N-1 shifts the MSB sits at the LSB position.
               if (r_cnt == CW'(N - 2)) begin
                  r_estado <= FINAL;
               end
            end
            FINAL: begin
               r_resultado <= p_x;
               r_listo     <= 1'b1;
               r_estado    <= REPOSO;
            end
            default: begin
               r_estado <= REPOSO;
            end
         endcase
      end
   end

   assign a_p           = r_sa[0];
   assign b_p           = r_sb[0];
   assign x_p           = r_x;
   assign ultimo        = (r_estado == FINAL);
   assign bus.ocupado   = (r_estado == DESPLAZA) || (r_estado == FINAL);
   assign bus.listo     = r_listo;
   assign bus.resultado = r_resultado;

endmodule

// File: doc/comparador_serie_d_i.md
# comparador_serie_d_i

Bit-serial unsigned magnitude comparator that processes two N-bit words right to left (LSB first) and sits directly upstream of the final comparator cell. It loads A and B in parallel on a start handshake and shifts them out one bit per clock. It keeps the running borrow state in a register. On the last bit (MSB) it drives the final cell's a_p/b_p/x_p inputs and captures that cell's p_x output as the comparison result.

## Interface
- N, default 8: word width; legal range N >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in REPOSO.
- modo  input  1  initial state x0, captured at start. 0 selects A >= B; 1 selects A > B.
- a_in  input  N  word A, captured at start.
- b_in  input  N  word B, captured at start.
- p_x  input  1  result from the final cell, combinational from a_p/b_p/x_p.
- a_p  output  1  current A bit, which is the LSB of the A shift register.
- b_p  output  1  current B bit, which is the LSB of the B shift register.
- x_p  output  1  current state, which is the borrow register.
- ultimo  output  1  high while the MSB is presented to the final cell (state FINAL).
- ocupado  output  1  high in DESPLAZA and FINAL.
- listo  output  1  one-cycle pulse when resultado has been updated.
- resultado  output  1  registered comparison result; holds until the next update.

## Operation
- Registers:
  - sa, sb: N-bit shift registers.
  - x: 1 bit.
  - cnt: ceil(log2 N) bits.
  - estado: one of REPOSO, DESPLAZA, FINAL.
  - resultado, listo.
- Reset (asynchronous, rst_n = 0):
  - estado = REPOSO; sa = sb = 0; x = 0; cnt = 0; resultado = 0; listo = 0.
  - Consequently a_p = b_p = x_p = ultimo = ocupado = 0.
- REPOSO:
  - If start = 1: sa <= a_in, sb <= b_in, x <= modo, cnt <= 0, go to DESPLAZA.
  - Otherwise hold.
- DESPLAZA (intermediate cell, one bit per cycle):
  - With a = sa[0] and b = sb[0]: x <= (~a & b) | (~a & x) | (b & x). This is the borrow-out of a - b - x.
  - sa <= sa >> 1 and sb <= sb >> 1, zero-filled.
  - cnt <= cnt + 1.
  - When cnt = N-2 this cycle, go to FINAL.
- FINAL:
  - ultimo = 1; a_p/b_p carry the original MSBs; x_p carries the borrow from bits N-2..0.
  - resultado <= p_x; listo <= 1; go to REPOSO.
  - Registers sa, sb and x hold their values.
- The expected p_x equals (~x_p & ~b_p) | (~b_p & a_p) | (~x_p & a_p), the complement of the final borrow.
- resultado = 1 iff unsigned A >= B + modo.
- listo is cleared in every cycle that is not the cycle following FINAL.
- start while ocupado = 1 is ignored, and in-flight data is not disturbed.
- a_in, b_in and modo are don't-care except at the accepting edge.

## Timing
- Edge 0 accepts start.
- Cycles 1..N-1 are DESPLAZA; cycle N is FINAL.
- ocupado = 1 in cycles 1..N; ultimo = 1 in cycle N only.
- resultado is updated at the end of cycle N. listo = 1 during cycle N+1.
- Total latency is N+1 cycles from start to listo.
- Back-to-back operation:
  - start in cycle N+1 (REPOSO, listo high) is accepted.
  - The new operation's cycle 1 is therefore cycle N+2, giving a throughput of one compare per N+1 cycles.
- Reset asserted mid-operation:
  - Immediate return to REPOSO with all outputs at their reset values.
  - No listo pulse; resultado is forced to 0, and the previous value is lost.
- p_x is sampled only in FINAL and may be X in other states.
- All outputs are registered or decoded from estado and registers; none depend combinationally on inputs.

## Test plan
Each scenario runs with N = 8 and a behavioural final cell attached.
- Equality and mode:
  - A = 0x5A, B = 0x5A, modo = 0 -> listo in cycle 9, resultado = 1.
  - Same operands with modo = 1 -> resultado = 0.
- Extremes and MSB decision:
  - A = 0x00, B = 0xFF, modo = 0 -> resultado = 0.
  - A = 0x80, B = 0x7F -> resultado = 1.
  - The A = 0x80 case: in cycle 8, ultimo = 1, a_p = 1, b_p = 0, x_p = 1.
- Busy protection:
  - Start A = 0x10, B = 0x20; pulse start with A = 0xFF, B = 0x00 in cycle 3.
  - -> resultado = 0, only one listo pulse, ocupado high for exactly 8 cycles.
- Reset mid-operation:
  - Deassert rst_n asynchronously in cycle 4.
  - -> outputs go to 0 before the next edge, no listo follows, and estado = REPOSO.
  - A subsequent compare of A = 0x03, B = 0x02 -> resultado = 1.
- Back-to-back:
  - First compare A = 0x01, B = 0x02 (resultado = 0), with start held high through cycle 9 and A = 0x02, B = 0x01.
  - -> second listo in cycle 18 with resultado = 1.
- Randomized sweep:
  - 1000 random A, B and modo values.
  - Check resultado against (A >= B + modo) and the listo latency of N+1.
